// File: rtl/higher_order_summation.sv
// Cascade of N integrators (running sums), one register stage per integrator.
// Each stage accumulates the previous stage's registered output, so results appear N qualified cycles later.
module higher_order_summation #(
  parameter int N        = 1,
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic                    clear,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] sum_out,
  output logic                    overflow
);

  // Handshake: valid-only, no ready. A sample is accepted on every rising edge with
  // clk_en=1, clear=0, valid_in=1; valid_out pulses for one qualified cycle per accepted
  // sample, N qualified cycles later. The block never stalls its producer.

  localparam logic signed [WIDTH-1:0] SUM_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SUM_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] acc       [N];
  logic        [N-1:0]     v;
  logic signed [WIDTH-1:0] stage_in  [N];
  logic        [N-1:0]     stage_vin;
  logic signed [WIDTH:0]   wide_sum  [N];
  logic signed [WIDTH-1:0] acc_next  [N];
  logic        [N-1:0]     stage_oor;

  // Stage k consumes the registered output of stage k-1.
  always_comb begin
    stage_in     = '{default: '0};
    stage_vin    = '0;
    stage_in[0]  = x_in;
    stage_vin[0] = valid_in;
    for (int k = 1; k < N; k++) begin
      stage_in[k]  = acc[k-1];
      stage_vin[k] = v[k-1];
    end
  end

  // One extra bit of headroom; the top two bits disagree exactly when the result left the signed range.
  always_comb begin
    wide_sum  = '{default: '0};
    acc_next  = '{default: '0};
    stage_oor = '0;
    for (int k = 0; k < N; k++) begin
      wide_sum[k]  = {acc[k][WIDTH-1], acc[k]} + {stage_in[k][WIDTH-1], stage_in[k]};
      stage_oor[k] = wide_sum[k][WIDTH] ^ wide_sum[k][WIDTH-1];
      if (stage_oor[k] && SATURATE)
        acc_next[k] = wide_sum[k][WIDTH] ? SUM_MIN : SUM_MAX;
      else
        acc_next[k] = wide_sum[k][WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) acc[k] <= '0;
      v        <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < N; k++) acc[k] <= '0;
      v        <= '0;
      overflow <= 1'b0;
    end else if (clk_en) begin
      v <= stage_vin;
      for (int k = 0; k < N; k++)
        if (stage_vin[k]) acc[k] <= acc_next[k];
      if (|(stage_oor & stage_vin)) overflow <= 1'b1;
    end
  end

  assign valid_out = v[N-1];
  assign sum_out   = acc[N-1];

endmodule
